// File: rtl/alu_execute_stage_pkg.sv
// Shared ALU control encoding and helpers for the execute stage and the
// combinational ALU it instantiates.
package alu_execute_stage_pkg;

  localparam int unsigned ALU_SHAMT_W = 5;

  typedef enum logic [4:0] {
    ALU_CTRL_ADD   = 5'd0,
    ALU_CTRL_SUB   = 5'd1,
    ALU_CTRL_XOR   = 5'd2,
    ALU_CTRL_OR    = 5'd3,
    ALU_CTRL_AND   = 5'd4,
    ALU_CTRL_SLL   = 5'd5,
    ALU_CTRL_SRL   = 5'd6,
    ALU_CTRL_SRA   = 5'd7,
    ALU_CTRL_SLT   = 5'd8,
    ALU_CTRL_SLTU  = 5'd9,
    ALU_CTRL_LUI   = 5'd10,
    ALU_CTRL_AUIPC = 5'd11,
    ALU_CTRL_BEQ   = 5'd12,
    ALU_CTRL_BNE   = 5'd13,
    ALU_CTRL_BLT   = 5'd14,
    ALU_CTRL_BGE   = 5'd15,
    ALU_CTRL_BLTU  = 5'd16,
    ALU_CTRL_BGEU  = 5'd17
  } AluControl_t;

  function automatic logic is_branch_ctrl(input AluControl_t ctrl);
    return ctrl inside {ALU_CTRL_BEQ, ALU_CTRL_BNE, ALU_CTRL_BLT,
                        ALU_CTRL_BGE, ALU_CTRL_BLTU, ALU_CTRL_BGEU};
  endfunction

endpackage

// File: rtl/alu_execute_stage_alu.sv
// Combinational ALU: arithmetic/logic result plus branch condition.
// Kept stateless so a multi-cycle unit can reuse it.
import alu_execute_stage_pkg::*;

module alu #(
  parameter int unsigned XLEN = 32
) (
  input  AluControl_t     ctrl_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] result_o,
  output logic            branch_taken_o
);

  logic [ALU_SHAMT_W-1:0] shamt;
  logic                   lt_s;
  logic                   lt_u;
  logic                   eq;

  assign shamt = b_i[ALU_SHAMT_W-1:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;
  assign eq    = a_i == b_i;

  always_comb begin
    result_o       = a_i + b_i;
    branch_taken_o = 1'b0;
    case (ctrl_i)
      ALU_CTRL_SUB:   result_o = a_i - b_i;
      ALU_CTRL_XOR:   result_o = a_i ^ b_i;
      ALU_CTRL_OR:    result_o = a_i | b_i;
      ALU_CTRL_AND:   result_o = a_i & b_i;
      ALU_CTRL_SLL:   result_o = a_i << shamt;
      ALU_CTRL_SRL:   result_o = a_i >> shamt;
      ALU_CTRL_SRA:   result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_CTRL_SLT:   result_o = {{(XLEN-1){1'b0}}, lt_s};
      ALU_CTRL_SLTU:  result_o = {{(XLEN-1){1'b0}}, lt_u};
      ALU_CTRL_LUI:   result_o = b_i;
      ALU_CTRL_AUIPC: result_o = pc_i + b_i;
      ALU_CTRL_BEQ, ALU_CTRL_BNE, ALU_CTRL_BLT,
      ALU_CTRL_BGE, ALU_CTRL_BLTU, ALU_CTRL_BGEU: begin
        // Branches write the link value; the condition goes out separately.
        result_o = pc_i + XLEN'(4);
        case (ctrl_i)
          ALU_CTRL_BEQ:  branch_taken_o = eq;
          ALU_CTRL_BNE:  branch_taken_o = !eq;
          ALU_CTRL_BLT:  branch_taken_o = lt_s;
          ALU_CTRL_BGE:  branch_taken_o = !lt_s;
          ALU_CTRL_BLTU: branch_taken_o = lt_u;
          default:       branch_taken_o = !lt_u;
        endcase
      end
      default:        result_o = a_i + b_i;
    endcase
  end

endmodule

// File: rtl/alu_execute_stage.sv
// Execute stage: ID/EX and EX/MEM registers with valid/ready handshake
// and branch redirect towards fetch.
import alu_execute_stage_pkg::*;

module alu_execute_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  flush_i,
  input  AluControl_t           AluControlD,
  input  logic [XLEN-1:0]       SrcAD,
  input  logic [XLEN-1:0]       SrcBD,
  input  logic [XLEN-1:0]       PCD,
  input  logic [XLEN-1:0]       ImmExtD,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  RegWriteD,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [XLEN-1:0]       AluResultM,
  output logic [REG_ADDR_W-1:0] RdM,
  output logic                  RegWriteM,
  output logic                  redirect_o,
  output logic [XLEN-1:0]       PCTargetE
);

  logic                  e_valid_d, e_valid_q;
  AluControl_t           e_ctrl_d, e_ctrl_q;
  logic [XLEN-1:0]       e_a_d, e_a_q, e_b_d, e_b_q;
  logic [XLEN-1:0]       e_pc_d, e_pc_q, e_imm_d, e_imm_q;
  logic [REG_ADDR_W-1:0] e_rd_d, e_rd_q;
  logic                  e_rw_d, e_rw_q;

  logic                  m_valid_d, m_valid_q;
  logic [XLEN-1:0]       m_result_d, m_result_q;
  logic [REG_ADDR_W-1:0] m_rd_d, m_rd_q;
  logic                  m_rw_d, m_rw_q;

  logic                  m_ready, e_adv, in_fire;
  logic [XLEN-1:0]       alu_result;
  logic                  alu_taken;

  alu #(.XLEN(XLEN)) u_alu (
    .ctrl_i         (e_ctrl_q),
    .a_i            (e_a_q),
    .b_i            (e_b_q),
    .pc_i           (e_pc_q),
    .result_o       (alu_result),
    .branch_taken_o (alu_taken)
  );

  assign m_ready    = !m_valid_q || out_ready_i;
  assign e_adv      = e_valid_q && m_ready;
  assign in_ready_o = !e_valid_q || m_ready;
  assign in_fire    = in_valid_i && in_ready_o && !flush_i;

  assign redirect_o  = e_adv && is_branch_ctrl(e_ctrl_q) && alu_taken;
  assign PCTargetE   = e_pc_q + e_imm_q;
  assign out_valid_o = m_valid_q;
  assign AluResultM  = m_result_q;
  assign RdM         = m_rd_q;
  assign RegWriteM   = m_rw_q;

  always_comb begin
    e_valid_d  = e_valid_q;
    e_ctrl_d   = e_ctrl_q;
    e_a_d      = e_a_q;
    e_b_d      = e_b_q;
    e_pc_d     = e_pc_q;
    e_imm_d    = e_imm_q;
    e_rd_d     = e_rd_q;
    e_rw_d     = e_rw_q;
    m_valid_d  = m_valid_q;
    m_result_d = m_result_q;
    m_rd_d     = m_rd_q;
    m_rw_d     = m_rw_q;
    // E load condition equals in_ready_o: a held entry is never flushed.
    if (in_ready_o) begin
      e_valid_d = in_fire;
      e_ctrl_d  = AluControlD;
      e_a_d     = SrcAD;
      e_b_d     = SrcBD;
      e_pc_d    = PCD;
      e_imm_d   = ImmExtD;
      e_rd_d    = RdD;
      e_rw_d    = RegWriteD;
    end
    if (m_ready) begin
      m_valid_d  = e_adv;
      m_result_d = alu_result;
      m_rd_d     = e_rd_q;
      m_rw_d     = e_adv && e_rw_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_valid_q  <= 1'b0;
      e_ctrl_q   <= ALU_CTRL_ADD;
      e_a_q      <= '0;
      e_b_q      <= '0;
      e_pc_q     <= '0;
      e_imm_q    <= '0;
      e_rd_q     <= '0;
      e_rw_q     <= 1'b0;
      m_valid_q  <= 1'b0;
      m_result_q <= '0;
      m_rd_q     <= '0;
      m_rw_q     <= 1'b0;
    end else begin
      e_valid_q  <= e_valid_d;
      e_ctrl_q   <= e_ctrl_d;
      e_a_q      <= e_a_d;
      e_b_q      <= e_b_d;
      e_pc_q     <= e_pc_d;
      e_imm_q    <= e_imm_d;
      e_rd_q     <= e_rd_d;
      e_rw_q     <= e_rw_d;
      m_valid_q  <= m_valid_d;
      m_result_q <= m_result_d;
      m_rd_q     <= m_rd_d;
      m_rw_q     <= m_rw_d;
    end
  end

endmodule

// File: tb/tb_alu_execute_stage.sv
// Directed bench for the execute stage: ALU ops, branches with redirect,
// back-pressure and asynchronous reset.
import alu_execute_stage_pkg::*;

module tb_alu_execute_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid_i, in_ready_o, flush_i;
  AluControl_t AluControlD;
  logic [31:0] SrcAD, SrcBD, PCD, ImmExtD;
  logic [4:0]  RdD;
  logic        RegWriteD;
  logic        out_valid_o, out_ready_i;
  logic [31:0] AluResultM;
  logic [4:0]  RdM;
  logic        RegWriteM, redirect_o;
  logic [31:0] PCTargetE;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  alu_execute_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .flush_i     (flush_i),
    .AluControlD (AluControlD),
    .SrcAD       (SrcAD),
    .SrcBD       (SrcBD),
    .PCD         (PCD),
    .ImmExtD     (ImmExtD),
    .RdD         (RdD),
    .RegWriteD   (RegWriteD),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .AluResultM  (AluResultM),
    .RdM         (RdM),
    .RegWriteM   (RegWriteM),
    .redirect_o  (redirect_o),
    .PCTargetE   (PCTargetE)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input AluControl_t ctrl, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd);
    AluControlD = ctrl;
    SrcAD       = a;
    SrcBD       = b;
    PCD         = pc;
    ImmExtD     = imm;
    RdD         = rd;
    RegWriteD   = 1'b1;
    in_valid_i  = 1'b1;
  endtask

  // Called at a negedge with out_ready_i=1; returns at a negedge with the pipe empty.
  task automatic run_one(input string tag, input AluControl_t ctrl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [4:0] rd, input logic exp_redir, input logic [31:0] exp_tgt,
                         input logic [31:0] exp_res);
    drive(ctrl, a, b, pc, imm, rd);
    @(posedge clk); @(negedge clk);
    in_valid_i = 1'b0;
    check_eq({tag, ".early_valid"}, {31'b0, out_valid_o}, 32'd0);
    check_eq({tag, ".redirect"}, {31'b0, redirect_o}, {31'b0, exp_redir});
    if (exp_redir) check_eq({tag, ".target"}, PCTargetE, exp_tgt);
    @(posedge clk); @(negedge clk);
    check_eq({tag, ".valid"}, {31'b0, out_valid_o}, 32'd1);
    check_eq({tag, ".result"}, AluResultM, exp_res);
    check_eq({tag, ".rd"}, {27'b0, RdM}, {27'b0, rd});
    check_eq({tag, ".redir_gone"}, {31'b0, redirect_o}, 32'd0);
    @(posedge clk); @(negedge clk);
    check_eq({tag, ".drained"}, {31'b0, out_valid_o}, 32'd0);
  endtask

  initial begin
    resetn = 1'b0; in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    AluControlD = ALU_CTRL_ADD; SrcAD = '0; SrcBD = '0; PCD = '0; ImmExtD = '0;
    RdD = '0; RegWriteD = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst.valid", {31'b0, out_valid_o}, 32'd0);
    check_eq("rst.regwrite", {31'b0, RegWriteM}, 32'd0);
    check_eq("rst.redirect", {31'b0, redirect_o}, 32'd0);
    check_eq("rst.result", AluResultM, 32'd0);
    check_eq("rst.in_ready", {31'b0, in_ready_o}, 32'd1);
    resetn = 1'b1;
    @(negedge clk);

    run_one("add",   ALU_CTRL_ADD,  32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 5'd1, 1'b0, 32'h0, 32'h80000000);
    run_one("sra",   ALU_CTRL_SRA,  32'h80000010, 32'h24, 32'h0, 32'h0, 5'd2, 1'b0, 32'h0, 32'hF8000001);
    run_one("srl",   ALU_CTRL_SRL,  32'h80000010, 32'h24, 32'h0, 32'h0, 5'd3, 1'b0, 32'h0, 32'h08000001);
    run_one("sll",   ALU_CTRL_SLL,  32'h00000003, 32'h21, 32'h0, 32'h0, 5'd4, 1'b0, 32'h0, 32'h00000006);
    run_one("sub",   ALU_CTRL_SUB,  32'h0, 32'h1, 32'h0, 32'h0, 5'd5, 1'b0, 32'h0, 32'hFFFFFFFF);
    run_one("xor",   ALU_CTRL_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0, 5'd6, 1'b0, 32'h0, 32'h0FF00FF0);
    run_one("or",    ALU_CTRL_OR,   32'hF0F0F0F0, 32'h0F000000, 32'h0, 32'h0, 5'd7, 1'b0, 32'h0, 32'hFFF0F0F0);
    run_one("and",   ALU_CTRL_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0, 5'd8, 1'b0, 32'h0, 32'hF000F000);
    run_one("slt",   ALU_CTRL_SLT,  32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 5'd9, 1'b0, 32'h0, 32'h1);
    run_one("sltu",  ALU_CTRL_SLTU, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 5'd10, 1'b0, 32'h0, 32'h0);
    run_one("lui",   ALU_CTRL_LUI,  32'h12345678, 32'hABCDE000, 32'h0, 32'h0, 5'd11, 1'b0, 32'h0, 32'hABCDE000);
    run_one("auipc", ALU_CTRL_AUIPC, 32'h0, 32'h00001000, 32'h200, 32'h0, 5'd12, 1'b0, 32'h0, 32'h00001200);
    run_one("undef", AluControl_t'(5'd31), 32'h3, 32'h4, 32'h0, 32'h0, 5'd13, 1'b0, 32'h0, 32'h7);
    run_one("bge",   ALU_CTRL_BGE,  32'hFFFFFFFF, 32'h1, 32'h300, 32'h40, 5'd0, 1'b0, 32'h0, 32'h304);
    run_one("bgeu",  ALU_CTRL_BGEU, 32'hFFFFFFFF, 32'h1, 32'h300, 32'h40, 5'd0, 1'b1, 32'h340, 32'h304);
    run_one("bne",   ALU_CTRL_BNE,  32'h5, 32'h5, 32'h400, 32'h8, 5'd0, 1'b0, 32'h0, 32'h404);

    // Taken BEQ; the following decode bundle is flushed in the redirect cycle.
    drive(ALU_CTRL_BEQ, 32'h5, 32'h5, 32'h100, 32'h20, 5'd0);
    @(posedge clk); @(negedge clk);
    check_eq("beq.redirect", {31'b0, redirect_o}, 32'd1);
    check_eq("beq.target", PCTargetE, 32'h120);
    drive(ALU_CTRL_ADD, 32'h1, 32'h1, 32'h104, 32'h0, 5'd20);
    flush_i = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid_i = 1'b0; flush_i = 1'b0;
    check_eq("beq.valid", {31'b0, out_valid_o}, 32'd1);
    check_eq("beq.result", AluResultM, 32'h104);
    check_eq("beq.redir_once", {31'b0, redirect_o}, 32'd0);
    @(posedge clk); @(negedge clk);
    check_eq("flush.squashed", {31'b0, out_valid_o}, 32'd0);
    check_eq("flush.regwrite", {31'b0, RegWriteM}, 32'd0);

    // Back-pressure: three bundles offered while the memory stage stalls.
    out_ready_i = 1'b0;
    drive(ALU_CTRL_ADD, 32'd10, 32'd1, 32'h0, 32'h0, 5'd1);
    @(posedge clk); @(negedge clk);
    drive(ALU_CTRL_ADD, 32'd20, 32'd1, 32'h0, 32'h0, 5'd2);
    @(posedge clk); @(negedge clk);
    drive(ALU_CTRL_ADD, 32'd30, 32'd1, 32'h0, 32'h0, 5'd3);
    for (int i = 0; i < 2; i++) begin
      check_eq("bp.in_ready", {31'b0, in_ready_o}, 32'd0);
      check_eq("bp.valid", {31'b0, out_valid_o}, 32'd1);
      check_eq("bp.result", AluResultM, 32'd11);
      check_eq("bp.rd", {27'b0, RdM}, 32'd1);
      @(posedge clk); @(negedge clk);
    end
    check_eq("bp.stable", AluResultM, 32'd11);
    out_ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid_i = 1'b0;
    check_eq("bp.second", AluResultM, 32'd21);
    check_eq("bp.second_rd", {27'b0, RdM}, 32'd2);
    @(posedge clk); @(negedge clk);
    check_eq("bp.third", AluResultM, 32'd31);
    check_eq("bp.third_valid", {31'b0, out_valid_o}, 32'd1);
    @(posedge clk); @(negedge clk);
    check_eq("bp.empty", {31'b0, out_valid_o}, 32'd0);

    // Reset with both entries valid and a taken branch about to leave E.
    out_ready_i = 1'b0;
    drive(ALU_CTRL_ADD, 32'd1, 32'd2, 32'h0, 32'h0, 5'd7);
    @(posedge clk); @(negedge clk);
    drive(ALU_CTRL_BEQ, 32'd9, 32'd9, 32'h500, 32'h10, 5'd0);
    @(posedge clk); @(negedge clk);
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    #1;
    check_eq("rst2.pre_redirect", {31'b0, redirect_o}, 32'd1);
    resetn = 1'b0;
    #1;
    check_eq("rst2.valid", {31'b0, out_valid_o}, 32'd0);
    check_eq("rst2.redirect", {31'b0, redirect_o}, 32'd0);
    check_eq("rst2.regwrite", {31'b0, RegWriteM}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_one("post_rst", ALU_CTRL_SUB, 32'd100, 32'd58, 32'h0, 32'h0, 5'd15, 1'b0, 32'h0, 32'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
